// File: rtl/bht_update_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bht_update_buffer: FIFO of resolved {pc, taken} updates feeding the BHT      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module bht_update_buffer #(
    parameter int DEPTH      = 4,
    parameter int VLEN       = 64,
    parameter int DROP_CNT_W = 16
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    flush_i,
    input  logic                    debug_mode_i,
    input  logic                    upd_valid_i,
    input  logic [VLEN-1:0]         upd_pc_i,
    input  logic                    upd_taken_i,
    output logic                    bht_valid_o,
    output logic [VLEN-1:0]         bht_pc_o,
    output logic                    bht_taken_o,
    input  logic                    bht_ready_i,
    output logic [$clog2(DEPTH):0]  occupancy_o,
    output logic [DROP_CNT_W-1:0]   drop_cnt_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);

    logic [VLEN-1:0]       pc_q [DEPTH];
    logic [DEPTH-1:0]      taken_q;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DROP_CNT_W-1:0] drop_q, drop_d;

    logic w_full;
    logic w_req;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // A full buffer may still accept when the head leaves in the same cycle.
    always_comb begin
        w_full = (count_q == C_DEPTH);
        w_pop  = (count_q != '0) & bht_ready_i & ~flush_i;
        w_req  = upd_valid_i & ~debug_mode_i & ~flush_i;
        w_push = w_req & (~w_full | w_pop);
        w_drop = w_req & w_full & ~w_pop;
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (w_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
        if (w_drop && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                pc_q[gi]    <= '0;
                taken_q[gi] <= 1'b0;
            end else if (w_push && (wr_ptr_q == PTR_W'(gi))) begin
                pc_q[gi]    <= upd_pc_i;
                taken_q[gi] <= upd_taken_i;
            end
        end
    end

    assign bht_valid_o = (count_q != '0);
    assign bht_pc_o    = pc_q[rd_ptr_q];
    assign bht_taken_o = taken_q[rd_ptr_q];
    assign occupancy_o = count_q;
    assign drop_cnt_o  = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_bht_update_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_bht_update_buffer: vector table, directed corners and random vs. model    |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module tb_bht_update_buffer;

    localparam int DEPTH = 4;
    localparam int VLEN  = 64;
    localparam int DCW   = 16;
    localparam int DMAX  = 65535;

    logic            clk, rst, flush, debug, upd_valid, upd_taken, ready;
    logic [VLEN-1:0] upd_pc;
    logic            bht_valid, bht_taken;
    logic [VLEN-1:0] bht_pc;
    logic [2:0]      occ;
    logic [DCW-1:0]  drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    bht_update_buffer #(.DEPTH(DEPTH), .VLEN(VLEN), .DROP_CNT_W(DCW)) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .debug_mode_i(debug),
        .upd_valid_i(upd_valid), .upd_pc_i(upd_pc), .upd_taken_i(upd_taken),
        .bht_valid_o(bht_valid), .bht_pc_o(bht_pc), .bht_taken_o(bht_taken),
        .bht_ready_i(ready), .occupancy_o(occ), .drop_cnt_o(drop_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct packed {
        logic [VLEN-1:0] pc;
        logic            taken;
    } ent_t;

    ent_t        mq[$];
    int unsigned mdrop;

    typedef struct {
        logic            flush, debug, valid, taken, ready;
        logic [VLEN-1:0] pc;
        logic            e_valid, e_taken;
        logic [VLEN-1:0] e_pc;
        int              e_occ, e_drop;
    } vec_t;

    vec_t vt[12];

    task automatic cmp(input string nm, input logic [VLEN-1:0] act, input logic [VLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic f, input logic d, input logic v,
                         input logic [VLEN-1:0] pc, input logic t, input logic r);
        flush = f; debug = d; upd_valid = v; upd_pc = pc; upd_taken = t; ready = r;
    endtask

    // Reference: queue semantics straight from the behavioural rules.
    task automatic model_step();
        bit popped;
        ent_t e;
        if (flush) begin
            mq.delete();
        end else begin
            popped = (mq.size() > 0) && ready;
            if (popped) void'(mq.pop_front());
            if (upd_valid && !debug) begin
                if (mq.size() < DEPTH) begin
                    e.pc = upd_pc; e.taken = upd_taken;
                    mq.push_back(e);
                end else if (mdrop < DMAX) begin
                    mdrop++;
                end
            end
        end
    endtask

    task automatic check_model(input string tag);
        cmp({tag, ".valid"}, VLEN'(bht_valid), VLEN'(mq.size() > 0));
        cmp({tag, ".occ"},   VLEN'(occ),       VLEN'(mq.size()));
        cmp({tag, ".drop"},  VLEN'(drop_cnt),  VLEN'(mdrop));
        if (mq.size() > 0) begin
            cmp({tag, ".pc"},    bht_pc,          mq[0].pc);
            cmp({tag, ".taken"}, VLEN'(bht_taken), VLEN'(mq[0].taken));
        end
    endtask

    task automatic cyc(input logic f, input logic d, input logic v,
                       input logic [VLEN-1:0] pc, input logic t, input logic r,
                       input bit do_chk, input string tag);
        drive(f, d, v, pc, t, r);
        model_step();
        @(posedge clk);
        #1;
        if (do_chk) check_model(tag);
    endtask

    initial begin
        drive(0, 0, 0, '0, 0, 0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mq.delete();
        mdrop = 0;

        cmp("rst.valid", VLEN'(bht_valid), '0);
        cmp("rst.occ",   VLEN'(occ),       '0);
        cmp("rst.drop",  VLEN'(drop_cnt),  '0);
        cmp("rst.pc",    bht_pc,           '0);
        cmp("rst.taken", VLEN'(bht_taken), '0);

        // Single-entry latency, then overflow with ready low and an in-order drain.
        vt[0]  = '{0,0,1,1,1, 64'h8000_0010, 1,1, 64'h8000_0010, 1, 0};
        vt[1]  = '{0,0,0,0,1, 64'h0,         0,0, 64'h0,         0, 0};
        vt[2]  = '{0,0,1,0,0, 64'h100,       1,0, 64'h100,       1, 0};
        vt[3]  = '{0,0,1,1,0, 64'h104,       1,0, 64'h100,       2, 0};
        vt[4]  = '{0,0,1,0,0, 64'h108,       1,0, 64'h100,       3, 0};
        vt[5]  = '{0,0,1,1,0, 64'h10C,       1,0, 64'h100,       4, 0};
        vt[6]  = '{0,0,1,0,0, 64'h110,       1,0, 64'h100,       4, 1};
        vt[7]  = '{0,0,1,1,0, 64'h114,       1,0, 64'h100,       4, 2};
        vt[8]  = '{0,0,0,0,1, 64'h0,         1,1, 64'h104,       3, 2};
        vt[9]  = '{0,0,0,0,1, 64'h0,         1,0, 64'h108,       2, 2};
        vt[10] = '{0,0,0,0,1, 64'h0,         1,1, 64'h10C,       1, 2};
        vt[11] = '{0,0,0,0,1, 64'h0,         0,0, 64'h0,         0, 2};

        for (int i = 0; i < 12; i++) begin
            drive(vt[i].flush, vt[i].debug, vt[i].valid, vt[i].pc, vt[i].taken, vt[i].ready);
            @(posedge clk);
            #1;
            cmp($sformatf("vec%0d.valid", i), VLEN'(bht_valid), VLEN'(vt[i].e_valid));
            cmp($sformatf("vec%0d.occ", i),   VLEN'(occ),       VLEN'(vt[i].e_occ));
            cmp($sformatf("vec%0d.drop", i),  VLEN'(drop_cnt),  VLEN'(vt[i].e_drop));
            if (vt[i].e_valid) begin
                cmp($sformatf("vec%0d.pc", i),    bht_pc,           vt[i].e_pc);
                cmp($sformatf("vec%0d.taken", i), VLEN'(bht_taken), VLEN'(vt[i].e_taken));
            end
        end
        mq.delete();
        mdrop = 2;

        // Full buffer with simultaneous push and pop, then wrap-around streaming.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 64'h1F0 + 64'(i), 1'(i), 0, 1, "fill");
        cyc(0, 0, 1, 64'h200, 1, 1, 1, "fullpp");
        cmp("fullpp.occ4", VLEN'(occ), 64'd4);
        for (int i = 0; i < 20; i++) cyc(0, 0, 1, 64'h300 + 64'(4 * i), 1'(i >> 1), 1, 1, "wrap");
        for (int i = 0; i < 5; i++) cyc(0, 0, 0, '0, 0, 1, 1, "drain");

        // Flush with a concurrent update, then a post-flush push.
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 64'h400 + 64'(i), 0, 0, 1, "preflush");
        cyc(1, 0, 1, 64'h4FF, 1, 1, 1, "flush");
        cmp("flush.occ0", VLEN'(occ), 64'd0);
        cyc(0, 0, 1, 64'h500, 1, 0, 1, "postflush");
        cmp("postflush.pc", bht_pc, 64'h500);
        cyc(0, 0, 0, '0, 0, 1, 1, "postflush.drain");

        // Debug mode drains the queue but blocks new pushes.
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 64'h600 + 64'(i), 1, 0, 1, "predbg");
        for (int i = 0; i < 3; i++) cyc(0, 1, 1, 64'h700 + 64'(i), 1, 1, 1, "dbg");
        cmp("dbg.occ0", VLEN'(occ), 64'd0);

        // Asynchronous reset between edges.
        for (int i = 0; i < 2; i++) cyc(0, 0, 1, 64'h800 + 64'(i), 1, 0, 1, "prerst");
        #2 rst = 1'b1;
        #1;
        cmp("arst.valid", VLEN'(bht_valid), '0);
        cmp("arst.occ",   VLEN'(occ),       '0);
        cmp("arst.drop",  VLEN'(drop_cnt),  '0);
        @(negedge clk);
        rst = 1'b0;
        mq.delete();
        mdrop = 0;
        drive(0, 0, 0, '0, 0, 0);
        @(posedge clk);
        #1 check_model("postrst");

        // Drop counter saturation.
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 64'h900 + 64'(i), 0, 0, 1, "satfill");
        for (int i = 0; i < 65536 + 5; i++) cyc(0, 0, 1, 64'hA00, 1, 0, 0, "sat");
        cmp("sat.drop", VLEN'(drop_cnt), 64'hFFFF);
        check_model("sat");
        cyc(1, 0, 0, '0, 0, 0, 1, "satflush");

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom % 32) == 0, ($urandom % 8) == 0, ($urandom % 10) < 7,
                {$urandom, $urandom}, 1'($urandom), 1'($urandom), 1, "rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bht_update_buffer.md
Name: bht_update_buffer

Overview:
- Decouples resolved-branch outcomes from the BHT write port.
- Captures one {pc, taken} update per cycle from the branch unit and queues it in a small circular FIFO.
- Drains one update per cycle into the BHT update port using a valid/ready handshake, so a BHT busy interval never loses updates until the buffer is full.
- Sits directly upstream of the BHT, between the branch-resolution logic and the BHT update interface.

Parameters:
DEPTH, 4, number of queued updates; power of two, >=2.
VLEN, 64, PC width in bits.
DROP_CNT_W, 16, width of the saturating dropped-update counter.

Ports:
clk_i  in  1  single clock; all state changes on its rising edge.
rst_i  in  1  reset, asynchronous, active-high.
flush_i  in  1  discards all queued entries; highest priority.
debug_mode_i  in  1  when 1, incoming updates are ignored (not queued, not counted).
upd_valid_i  in  1  resolved branch update present this cycle.
upd_pc_i  in  VLEN  PC of the resolved branch.
upd_taken_i  in  1  resolved direction.
bht_valid_o  out  1  head entry valid toward BHT.
bht_pc_o  out  VLEN  head entry PC.
bht_taken_o  out  1  head entry direction.
bht_ready_i  in  1  BHT accepts the head entry this cycle.
occupancy_o  out  $clog2(DEPTH)+1  number of queued entries.
drop_cnt_o  out  DROP_CNT_W  saturating count of updates lost to overflow.

Behaviour:
- Reset (async on rst_i high, released synchronously by design): read ptr=0, write ptr=0, occupancy_o=0, bht_valid_o=0, bht_pc_o=0, bht_taken_o=0, drop_cnt_o=0.
- Storage: DEPTH-entry array, read/write pointers $clog2(DEPTH) bits wide, wrapping DEPTH-1 -> 0. Count register is separate, 0..DEPTH.
- Push condition: push = upd_valid_i & ~debug_mode_i & ~flush_i & (count<DEPTH | pop).
- Pop condition: pop = bht_valid_o & bht_ready_i & ~flush_i.
- Output mapping: bht_valid_o = (count!=0). bht_pc_o and bht_taken_o are driven from the entry at the read pointer.
- No bypass: an update pushed in cycle N is first visible on bht_valid_o in cycle N+1. Minimum latency is 1 cycle; throughput is 1/cycle.
- Full buffer, push with no pop: the incoming update is dropped and drop_cnt_o increments, saturating at all-ones. The existing queue is unchanged.
- Full buffer, simultaneous push and pop: both happen; count stays DEPTH; no drop.
- Empty buffer with push: count goes to 1. bht_ready_i while empty has no effect.
- Count update: count_next = count + push - pop.
- Outputs are stable while bht_valid_o=1 and bht_ready_i=0. The head entry must not change until popped.
- flush_i=1: next cycle has count=0, pointers=0, bht_valid_o=0. An update presented in the flush cycle is discarded and not counted as a drop. drop_cnt_o is preserved.
- debug_mode_i=1: queued entries continue to drain normally; only new pushes are blocked.
- Same-PC updates are not merged; each accepted update reaches the BHT in arrival order.
- Reset asserted mid-drain: all state is cleared immediately (asynchronously). bht_valid_o falls in the same cycle, without waiting for a clock edge.

Test Plan:
- Reset, then push pc=0x8000_0010 taken=1 in cycle 0 with bht_ready_i=1 -> cycle 1: bht_valid_o=1, pc=0x8000_0010, taken=1; cycle 2: bht_valid_o=0, occupancy_o=0.
- bht_ready_i=0, push 6 updates pc=0x100,0x104,...,0x114 back-to-back (DEPTH=4) -> occupancy_o=4, drop_cnt_o=2. Then ready=1: BHT receives 0x100,0x104,0x108,0x10C in order, then bht_valid_o=0.
- Full buffer, ready=1 and push pc=0x200 in the same cycle -> no drop; occupancy_o stays 4; 0x200 emerges 4 pops later. Continuous push+pop for 20 cycles checks pointer wrap-around with order preserved.
- Queue 3 entries, assert flush_i with upd_valid_i=1 -> next cycle occupancy_o=0, bht_valid_o=0, drop_cnt_o unchanged. A push after flush appears 1 cycle later.
- debug_mode_i=1 with 2 entries queued and 3 incoming updates, ready=1 -> only the 2 queued entries drain; drop_cnt_o unchanged; occupancy_o=0 after 2 cycles.
- Assert rst_i between clock edges with 2 entries queued -> bht_valid_o=0 and occupancy_o=0 before the next edge. Force 2^16+5 overflow drops -> drop_cnt_o=0xFFFF.
